// File: rtl/hilo_divider.sv
// Iterative radix-2 restoring divider producing DIV/DIVU results for the HI/LO unit.
// One quotient bit per cycle; remainder on hi_out, quotient on lo_out, single-cycle done pulse.
module hilo_divider #(
    parameter int unsigned BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [BUS_WIDTH-1:0] in1,
    input  logic [BUS_WIDTH-1:0] in2,
    input  logic                 is_signed,
    output logic                 busy,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] hi_out,
    output logic [BUS_WIDTH-1:0] lo_out,
    output logic                 div_by_zero
);

    localparam int unsigned CNT_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [BUS_WIDTH-1:0] r_rem;
    logic [BUS_WIDTH-1:0] r_quo;
    logic [BUS_WIDTH-1:0] r_divisor;
    logic [BUS_WIDTH-1:0] r_dividend_raw;
    logic                 r_q_neg;
    logic                 r_r_neg;
    logic                 r_dz;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_accept;
    logic                 w_in1_neg;
    logic                 w_in2_neg;
    logic [BUS_WIDTH-1:0] w_in1_mag;
    logic [BUS_WIDTH-1:0] w_in2_mag;
    logic [BUS_WIDTH:0]   w_rem_sh;
    logic [BUS_WIDTH:0]   w_trial;
    logic                 w_trial_neg;
    logic [BUS_WIDTH-1:0] w_rem_nxt;
    logic [BUS_WIDTH-1:0] w_quo_nxt;
    logic [BUS_WIDTH-1:0] w_lo_fix;
    logic [BUS_WIDTH-1:0] w_hi_fix;

    // Operand magnitudes; -2^(W-1) negates to itself, which is the correct unsigned magnitude.
    assign w_accept  = start_valid & start_ready;
    assign w_in1_neg = is_signed & in1[BUS_WIDTH-1];
    assign w_in2_neg = is_signed & in2[BUS_WIDTH-1];
    assign w_in1_mag = w_in1_neg ? (BUS_WIDTH'(0) - in1) : in1;
    assign w_in2_mag = w_in2_neg ? (BUS_WIDTH'(0) - in2) : in2;

    // Stored remainder is always below the divisor, so W bits hold it; the shifted value needs W+1.
    assign w_rem_sh    = {r_rem, r_quo[BUS_WIDTH-1]};
    assign w_trial     = w_rem_sh - {1'b0, r_divisor};
    assign w_trial_neg = w_trial[BUS_WIDTH];
    assign w_rem_nxt   = w_trial_neg ? w_rem_sh[BUS_WIDTH-1:0] : w_trial[BUS_WIDTH-1:0];
    assign w_quo_nxt   = {r_quo[BUS_WIDTH-2:0], ~w_trial_neg};

    assign w_lo_fix = r_q_neg ? (BUS_WIDTH'(0) - r_quo) : r_quo;
    assign w_hi_fix = r_r_neg ? (BUS_WIDTH'(0) - r_rem) : r_rem;

    // Control FSM with registered handshake, status and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_rem          <= '0;
            r_quo          <= '0;
            r_divisor      <= '0;
            r_dividend_raw <= '0;
            r_q_neg        <= 1'b0;
            r_r_neg        <= 1'b0;
            r_dz           <= 1'b0;
            r_cnt          <= '0;
            start_ready    <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            hi_out         <= '0;
            lo_out         <= '0;
            div_by_zero    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (w_accept) begin
                        r_rem          <= '0;
                        r_quo          <= w_in1_mag;
                        r_divisor      <= w_in2_mag;
                        r_dividend_raw <= in1;
                        r_q_neg        <= is_signed & (in1[BUS_WIDTH-1] ^ in2[BUS_WIDTH-1]);
                        r_r_neg        <= w_in1_neg;
                        r_cnt          <= CNT_W'(BUS_WIDTH - 1);
                        start_ready    <= 1'b0;
                        busy           <= 1'b1;
                        if (in2 == '0) begin
                            r_dz    <= 1'b1;
                            r_state <= S_FIXUP;
                        end else begin
                            r_dz    <= 1'b0;
                            r_state <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (r_cnt == '0) begin
                        r_state <= S_FIXUP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                // Zero divisor bypasses the sign fix: all-ones quotient, raw dividend as remainder.
                S_FIXUP: begin
                    if (r_dz) begin
                        lo_out <= '1;
                        hi_out <= r_dividend_raw;
                    end else begin
                        lo_out <= w_lo_fix;
                        hi_out <= w_hi_fix;
                    end
                    div_by_zero <= r_dz;
                    done        <= 1'b1;
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end

                default: begin
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
